// File: rtl/hazard_ctrl_if.sv
// Purpose : groups the pipeline-side hazard signals of hazard_ctrl into one bundle.
// Latency : wiring only, no storage.
// Backpr. : none; the stall and flush outputs are the pipeline's backpressure.
// Ports   : master = pipeline (drives the register IDs, enables and mem_ready,
//           and receives selects, stalls and flushes); slave = hazard_ctrl.
interface hazard_ctrl_if #(
   parameter int CNT_W = 16
);
   // Register IDs per stage.
   logic [3:0]       RA1D, RA2D, RA1E, RA2E;
   logic [3:0]       WA3E, WA3M, WA3W;
   // Per-stage control.
   logic             RegWriteM, RegWriteW, MemtoRegE, MemReqM, mem_ready;
   logic             PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE;
   // Controller outputs.
   logic [1:0]       ForwardAE, ForwardBE;
   logic             StallF, StallD, StallE, StallM;
   logic             FlushD, FlushE, FlushW;
   logic             mem_err;
   logic [CNT_W-1:0] stall_cycles;

   modport master (
      output RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
      output RegWriteM, RegWriteW, MemtoRegE, MemReqM, mem_ready,
      output PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
      input  ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
      input  FlushD, FlushE, FlushW, mem_err, stall_cycles
   );

   modport slave (
      input  RA1D, RA2D, RA1E, RA2E, WA3E, WA3M, WA3W,
      input  RegWriteM, RegWriteW, MemtoRegE, MemReqM, mem_ready,
      input  PCSrcD, PCSrcE, PCSrcM, PCSrcW, BranchTakenE,
      output ForwardAE, ForwardBE, StallF, StallD, StallE, StallM,
      output FlushD, FlushE, FlushW, mem_err, stall_cycles
   );
endinterface

// File: rtl/hazard_ctrl.sv
// Purpose : forwarding selects, load-use / PC-write stalls and flushes, data-memory wait FSM with timeout.
// Latency : stall/flush/forward outputs are combinational; mem_err and stall_cycles are registered.
// Backpr. : a not-ready data memory freezes F/D/E/M and bubbles MEM-WB until mem_ready; ERR freezes forever.
// Ports   : clk (rising edge), rst (synchronous, active-low), hif (hazard_ctrl_if.slave,
//           carries all register IDs, enables, selects, stalls, flushes, mem_err and stall_cycles).
module hazard_ctrl #(
   parameter int TIMEOUT = 15,
   parameter int CNT_W   = 16
) (
   input logic          clk,
   input logic          rst,
   hazard_ctrl_if.slave hif
);

   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      MEM_WAIT = 2'd1,
      ERR      = 2'd2
   } state_t;

   localparam logic [7:0]       TIMEOUT_C = 8'(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};

   state_t           state_q, state_d, state_eff;
   logic [7:0]       wcnt_q, wcnt_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;

   logic ldr_stall, pc_pend, mem_stall;
   logic stall_f;

   // Memory-stage result beats writeback result: it is the younger value.
   function automatic logic [1:0] fwd_sel(input logic [3:0] ra,
                                          input logic [3:0] wa_m, input logic we_m,
                                          input logic [3:0] wa_w, input logic we_w);
      logic [1:0] sel;
      sel = 2'b00;
      if (we_m && (ra == wa_m)) begin
         sel = 2'b10;
      end else if (we_w && (ra == wa_w)) begin
         sel = 2'b01;
      end
      return sel;
   endfunction

   // Holding rst low makes every combinational output behave as in IDLE,
   // even before the reset edge has actually cleared the state register.
   always_comb begin
      state_eff = rst ? state_q : IDLE;
   end

   // Wait-state FSM: next state, wait counter and the memory freeze.
   // The IDLE cycle that first sees a not-ready access already stalls,
   // so the stall length equals the number of mem_ready-low cycles.
   always_comb begin
      state_d   = state_q;
      wcnt_d    = wcnt_q;
      mem_stall = 1'b0;
      case (state_eff)
         IDLE: begin
            if (hif.MemReqM && !hif.mem_ready) begin
               mem_stall = 1'b1;
               state_d   = MEM_WAIT;
               wcnt_d    = 8'd1;
            end
         end
         MEM_WAIT: begin
            if (hif.mem_ready) begin
               state_d = IDLE;
               wcnt_d  = 8'd0;
            end else begin
               mem_stall = 1'b1;
               if (wcnt_q == TIMEOUT_C) begin
                  state_d = ERR;
               end else begin
                  wcnt_d = wcnt_q + 8'd1;
               end
            end
         end
         ERR: begin
            mem_stall = 1'b1;
         end
         default: begin
            state_d = IDLE;
            wcnt_d  = 8'd0;
         end
      endcase
   end

   // Hazard detection and output equations. A memory freeze suppresses the
   // D/E flushes so the frozen instructions survive until release.
   always_comb begin
      ldr_stall = hif.MemtoRegE && ((hif.RA1D == hif.WA3E) || (hif.RA2D == hif.WA3E));
      pc_pend   = hif.PCSrcD || hif.PCSrcE || hif.PCSrcM;
      stall_f   = ldr_stall || pc_pend || mem_stall;
   end

   assign hif.ForwardAE = fwd_sel(hif.RA1E, hif.WA3M, hif.RegWriteM, hif.WA3W, hif.RegWriteW);
   assign hif.ForwardBE = fwd_sel(hif.RA2E, hif.WA3M, hif.RegWriteM, hif.WA3W, hif.RegWriteW);
   assign hif.StallF    = stall_f;
   assign hif.StallD    = ldr_stall || mem_stall;
   assign hif.StallE    = mem_stall;
   assign hif.StallM    = mem_stall;
   assign hif.FlushW    = mem_stall;
   assign hif.FlushD    = !mem_stall && (pc_pend || hif.PCSrcW || hif.BranchTakenE);
   assign hif.FlushE    = !mem_stall && (ldr_stall || hif.BranchTakenE);

   // Stall-cycle counter holds at all-ones rather than wrapping.
   always_comb begin
      cnt_d = cnt_q;
      if (stall_f && (cnt_q != CNT_MAX)) begin
         cnt_d = cnt_q + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q <= IDLE;
         wcnt_q  <= 8'd0;
         cnt_q   <= '0;
      end else begin
         state_q <= state_d;
         wcnt_q  <= wcnt_d;
         cnt_q   <= cnt_d;
      end
   end

   // ERR is only left through reset, so the state itself is the sticky flag.
   assign hif.mem_err      = (state_q == ERR);
   assign hif.stall_cycles = cnt_q;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Bench for hazard_ctrl: directed scenarios followed by random cycles, all
// checked against a behavioural model that tracks the access in progress as a
// count of stalled cycles plus an error flag.
module tb_hazard_ctrl;

   localparam int TO   = 4;
   localparam int CW   = 4;
   localparam int CMAX = (1 << CW) - 1;

   logic clk;
   logic rst;
   int   total;
   int   bad;

   // Model state: stalled cycles of the current access, error flag, counter.
   int   m_wait;
   bit   m_err;
   int   m_cnt;

   hazard_ctrl_if #(.CNT_W(CW)) hif ();

   hazard_ctrl #(.TIMEOUT(TO), .CNT_W(CW)) dut (
      .clk (clk),
      .rst (rst),
      .hif (hif)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation exceeded time limit");
      $fatal(1, "watchdog");
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) else begin
         bad++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic clear_inputs();
      hif.RA1D = 4'd0; hif.RA2D = 4'd0; hif.RA1E = 4'd0; hif.RA2E = 4'd0;
      hif.WA3E = 4'd0; hif.WA3M = 4'd0; hif.WA3W = 4'd0;
      hif.RegWriteM = 1'b0; hif.RegWriteW = 1'b0; hif.MemtoRegE = 1'b0;
      hif.MemReqM = 1'b0; hif.mem_ready = 1'b0;
      hif.PCSrcD = 1'b0; hif.PCSrcE = 1'b0; hif.PCSrcM = 1'b0; hif.PCSrcW = 1'b0;
      hif.BranchTakenE = 1'b0;
   endtask

   function automatic logic [1:0] m_fwd(input logic [3:0] ra);
      if (hif.RegWriteM && ra == hif.WA3M) return 2'd2;
      if (hif.RegWriteW && ra == hif.WA3W) return 2'd1;
      return 2'd0;
   endfunction

   function automatic bit m_memstall();
      if (!rst) return hif.MemReqM && !hif.mem_ready;
      return m_err || ((m_wait > 0 || hif.MemReqM) && !hif.mem_ready);
   endfunction

   // {fa, fb, SF, SD, SE, SM, FD, FE, FW}
   function automatic logic [10:0] m_comb();
      bit ldr, pcp, ms;
      ldr = hif.MemtoRegE && (hif.RA1D == hif.WA3E || hif.RA2D == hif.WA3E);
      pcp = hif.PCSrcD || hif.PCSrcE || hif.PCSrcM;
      ms  = m_memstall();
      if (ms) return {m_fwd(hif.RA1E), m_fwd(hif.RA2E), 7'b1111001};
      return {m_fwd(hif.RA1E), m_fwd(hif.RA2E), ldr || pcp, ldr, 1'b0, 1'b0,
              pcp || hif.PCSrcW || hif.BranchTakenE, ldr || hif.BranchTakenE, 1'b0};
   endfunction

   function automatic logic [10:0] dut_comb();
      return {hif.ForwardAE, hif.ForwardBE, hif.StallF, hif.StallD, hif.StallE,
              hif.StallM, hif.FlushD, hif.FlushE, hif.FlushW};
   endfunction

   // One clock: check combinational outputs, advance model over the edge,
   // then check registered outputs. Called with inputs already applied.
   task automatic step(input string tag);
      logic [10:0] e;
      bit ms;
      #1;
      e  = m_comb();
      ms = m_memstall();
      chk({tag, "/comb"}, 32'(dut_comb()), 32'(e));
      @(posedge clk);
      if (!rst) begin
         m_wait = 0; m_err = 1'b0; m_cnt = 0;
      end else begin
         if (e[6] && m_cnt < CMAX) m_cnt++;
         if (!m_err) begin
            if (ms) begin
               m_wait++;
               if (m_wait == TO + 1) m_err = 1'b1;
            end else begin
               m_wait = 0;
            end
         end
      end
      #1;
      chk({tag, "/cnt"}, 32'(hif.stall_cycles), 32'(m_cnt));
      chk({tag, "/err"}, 32'(hif.mem_err), 32'(m_err));
      @(negedge clk);
   endtask

   task automatic do_reset();
      clear_inputs();
      rst = 1'b0;
      step("reset");
      rst = 1'b1;
   endtask

   initial begin
      total = 0; bad = 0;
      m_wait = 0; m_err = 1'b0; m_cnt = 0;
      clear_inputs();
      rst = 1'b0;

      // Reset state.
      step("init");
      chk("rst_cnt0", 32'(hif.stall_cycles), 32'd0);
      chk("rst_err0", 32'(hif.mem_err), 32'd0);
      rst = 1'b1;

      // Forwarding: M wins over W, then W, B side unmatched.
      hif.RA1E = 4'd3; hif.WA3M = 4'd3; hif.RegWriteM = 1'b1;
      hif.WA3W = 4'd3; hif.RegWriteW = 1'b1; hif.RA2E = 4'd5;
      #1;
      chk("fwdA_mem", 32'(hif.ForwardAE), 32'd2);
      chk("fwdB_none", 32'(hif.ForwardBE), 32'd0);
      step("fwd1");
      hif.RegWriteM = 1'b0;
      #1;
      chk("fwdA_wb", 32'(hif.ForwardAE), 32'd1);
      step("fwd2");
      clear_inputs();

      // Load-use.
      hif.MemtoRegE = 1'b1; hif.WA3E = 4'd2; hif.RA2D = 4'd2; hif.RA1D = 4'd7;
      #1;
      chk("ldr_bits", 32'({hif.StallF, hif.StallD, hif.FlushE, hif.FlushD, hif.StallM}), 32'b11100);
      step("ldr1");
      hif.MemtoRegE = 1'b0;
      #1;
      chk("ldr_clear", 32'({hif.StallF, hif.StallD, hif.FlushE}), 32'b000);
      step("ldr2");
      clear_inputs();

      // Branch taken, lone PCSrcD, load-use together with branch.
      hif.BranchTakenE = 1'b1;
      #1;
      chk("br_flush", 32'({hif.FlushD, hif.FlushE}), 32'b11);
      step("br1");
      clear_inputs();
      hif.PCSrcD = 1'b1;
      #1;
      chk("pcd_bits", 32'({hif.StallF, hif.FlushD, hif.FlushE}), 32'b110);
      step("pcd");
      clear_inputs();
      hif.MemtoRegE = 1'b1; hif.WA3E = 4'd6; hif.RA1D = 4'd6; hif.BranchTakenE = 1'b1;
      #1;
      chk("ldr_br", 32'({hif.StallF, hif.StallD, hif.FlushE, hif.FlushD}), 32'b1111);
      step("ldr_br");

      // Memory wait of three cycles.
      do_reset();
      hif.MemReqM = 1'b1; hif.mem_ready = 1'b0;
      for (int i = 0; i < 3; i++) begin
         #1;
         chk("mw_frozen", 32'({hif.StallF, hif.StallD, hif.StallE, hif.StallM, hif.FlushW}), 32'b11111);
         step("mw");
      end
      hif.mem_ready = 1'b1;
      #1;
      chk("mw_release", 32'(hif.StallM), 32'd0);
      step("mw_done");
      chk("mw_cnt3", 32'(hif.stall_cycles), 32'd3);
      // Back in IDLE: a ready access does not stall, no request does not stall.
      step("mw_zero");
      hif.MemReqM = 1'b0; hif.mem_ready = 1'b0;
      #1;
      chk("mw_idle", 32'(hif.StallM), 32'd0);
      step("mw_idle");

      // Timeout into ERR after TO+1 stalled cycles.
      do_reset();
      hif.MemReqM = 1'b1; hif.mem_ready = 1'b0;
      for (int i = 0; i < TO + 1; i++) begin
         step("to");
         chk("to_err", 32'(hif.mem_err), (i == TO) ? 32'd1 : 32'd0);
      end
      hif.mem_ready = 1'b1; hif.MemReqM = 1'b0;
      #1;
      chk("err_frozen", 32'(hif.StallM), 32'd1);
      step("err1");
      hif.BranchTakenE = 1'b1;
      #1;
      chk("prio_bits", 32'({hif.FlushD, hif.FlushE, hif.StallE}), 32'b001);
      step("prio");
      clear_inputs();
      rst = 1'b0;
      #1;
      chk("rst_idle", 32'(hif.StallM), 32'd0);
      step("err_rst");
      rst = 1'b1;
      chk("rst_err", 32'(hif.mem_err), 32'd0);
      chk("rst_cnt", 32'(hif.stall_cycles), 32'd0);

      // Saturation of the stall counter.
      hif.PCSrcD = 1'b1;
      for (int i = 0; i < 20; i++) step("sat");
      chk("sat_cnt", 32'(hif.stall_cycles), 32'(CMAX));
      clear_inputs();

      // Random traffic, occasional reset.
      for (int i = 0; i < 500; i++) begin
         rst           = ($urandom_range(0, 39) != 0);
         hif.RA1D      = 4'($urandom_range(0, 3));
         hif.RA2D      = 4'($urandom_range(0, 3));
         hif.RA1E      = 4'($urandom_range(0, 3));
         hif.RA2E      = 4'($urandom_range(0, 3));
         hif.WA3E      = 4'($urandom_range(0, 3));
         hif.WA3M      = 4'($urandom_range(0, 3));
         hif.WA3W      = 4'($urandom_range(0, 3));
         hif.RegWriteM = 1'($urandom_range(0, 1));
         hif.RegWriteW = 1'($urandom_range(0, 1));
         hif.MemtoRegE = ($urandom_range(0, 3) == 0);
         hif.MemReqM   = 1'($urandom_range(0, 1));
         hif.mem_ready = ($urandom_range(0, 9) < 6);
         hif.PCSrcD    = ($urandom_range(0, 7) == 0);
         hif.PCSrcE    = ($urandom_range(0, 7) == 0);
         hif.PCSrcM    = ($urandom_range(0, 7) == 0);
         hif.PCSrcW    = ($urandom_range(0, 7) == 0);
         hif.BranchTakenE = ($urandom_range(0, 5) == 0);
         step("rnd");
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
